// File: rtl/reassembly_meta_merge_if.sv
// Metadata type shared by the merge block and its neighbours, plus the bus
// interface bundling the three producer streams and the merged output.
//   slave  modport : merge block view (takes ino/fwd/reo streams and
//                    out_meta_ready; drives readies, almost_fulls,
//                    out_meta_*, ovf_err)
//   master modport : producer/consumer view (mirror of slave)
package reassembly_meta_pkg;
  localparam logic [1:0] PKT_CHECK   = 2'd0;
  localparam logic [1:0] PKT_FORWARD = 2'd1;
  localparam logic [1:0] PKT_DROP    = 2'd2;

  typedef struct packed {
    logic [1:0]  pkt_flags;
    logic [15:0] flow_id;
    logic [31:0] seq;
    logic [13:0] len;
  } metadata_t;

  localparam int META_WIDTH = $bits(metadata_t);
endpackage

interface reassembly_meta_merge_if;
  import reassembly_meta_pkg::*;

  metadata_t ino_meta_data;
  logic      ino_meta_valid;
  logic      ino_meta_almost_full;
  metadata_t fwd_meta_data;
  logic      fwd_meta_valid;
  logic      fwd_meta_ready;
  metadata_t reo_meta_data;
  logic      reo_meta_valid;
  logic      reo_meta_ready;
  logic      reo_meta_almost_full;
  metadata_t out_meta_data;
  logic      out_meta_valid;
  logic      out_meta_ready;
  logic      ovf_err;

  modport slave (
    input  ino_meta_data, ino_meta_valid,
    input  fwd_meta_data, fwd_meta_valid,
    input  reo_meta_data, reo_meta_valid,
    input  out_meta_ready,
    output ino_meta_almost_full, fwd_meta_ready,
    output reo_meta_ready, reo_meta_almost_full,
    output out_meta_data, out_meta_valid, ovf_err
  );

  modport master (
    output ino_meta_data, ino_meta_valid,
    output fwd_meta_data, fwd_meta_valid,
    output reo_meta_data, reo_meta_valid,
    output out_meta_ready,
    input  ino_meta_almost_full, fwd_meta_ready,
    input  reo_meta_ready, reo_meta_almost_full,
    input  out_meta_data, out_meta_valid, ovf_err
  );
endinterface

// File: rtl/reassembly_meta_merge.sv
// reassembly_meta_merge: merges the in-order (INO), forwarded (FWD) and
// reordered (REO) metadata streams from the flow-table stage into one
// registered stream using round-robin arbitration (FWD=0, INO=1, REO=2).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : the three producer streams, merged output, readies,
//                   almost_full flags and the sticky ovf_err flag
//   stat_check / stat_forward / stat_drop (32b) : handshake counters per
//                   pkt_flags value, present only when MERGE_STATS_EN is defined
// Producers of INO do not see a ready; they throttle on almost_full, and a
// write into a full INO FIFO is dropped and flagged.

module meta_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, wr_ok, rd_ok;

  // Fullness is judged on the registered count, so a pop in the same cycle
  // never makes room for a write into a full FIFO.
  assign full    = (count == CW'(DEPTH));
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module reassembly_meta_merge #(
  parameter int INO_DEPTH = 32,
  parameter int REO_DEPTH = 32,
  parameter int FWD_DEPTH = 4,
  parameter int AF_MARGIN = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  reassembly_meta_merge_if.slave   bus
`ifdef MERGE_STATS_EN
  ,
  output logic [31:0]              stat_check,
  output logic [31:0]              stat_forward,
  output logic [31:0]              stat_drop
`endif
);
  import reassembly_meta_pkg::*;

  localparam int INO_CW = $clog2(INO_DEPTH) + 1;
  localparam int REO_CW = $clog2(REO_DEPTH) + 1;
  localparam int FWD_CW = $clog2(FWD_DEPTH) + 1;
  localparam int INO_AF = INO_DEPTH - AF_MARGIN;
  localparam int REO_AF = REO_DEPTH - AF_MARGIN;

  localparam logic [1:0] SRC_FWD = 2'd0;
  localparam logic [1:0] SRC_INO = 2'd1;
  localparam logic [1:0] SRC_REO = 2'd2;

  logic [INO_CW-1:0] ino_cnt;
  logic [REO_CW-1:0] reo_cnt;
  logic [FWD_CW-1:0] fwd_cnt;
  metadata_t         ino_head, reo_head, fwd_head;
  logic              pop_fwd, pop_ino, pop_reo;

  logic              load;
  logic [2:0]        ne;
  logic [1:0]        rr_ptr;
  logic [1:0]        gnt, cand;
  logic              gnt_vld;
  metadata_t         gnt_data;
  metadata_t         out_data_q;
  logic              out_vld_q;
  logic              ovf_q;

  meta_fifo #(.DEPTH(FWD_DEPTH), .W(META_WIDTH)) u_fwd (
    .clk(clk), .rst(rst),
    .wr_en(bus.fwd_meta_valid), .wr_data(bus.fwd_meta_data),
    .rd_en(pop_fwd), .rd_data(fwd_head), .count(fwd_cnt)
  );

  meta_fifo #(.DEPTH(INO_DEPTH), .W(META_WIDTH)) u_ino (
    .clk(clk), .rst(rst),
    .wr_en(bus.ino_meta_valid), .wr_data(bus.ino_meta_data),
    .rd_en(pop_ino), .rd_data(ino_head), .count(ino_cnt)
  );

  meta_fifo #(.DEPTH(REO_DEPTH), .W(META_WIDTH)) u_reo (
    .clk(clk), .rst(rst),
    .wr_en(bus.reo_meta_valid), .wr_data(bus.reo_meta_data),
    .rd_en(pop_reo), .rd_data(reo_head), .count(reo_cnt)
  );

  // Flow-control outputs come straight off the registered counts.
  assign bus.fwd_meta_ready       = (fwd_cnt != FWD_CW'(FWD_DEPTH));
  assign bus.reo_meta_ready       = (reo_cnt != REO_CW'(REO_DEPTH));
  assign bus.ino_meta_almost_full = (ino_cnt >= INO_CW'(INO_AF));
  assign bus.reo_meta_almost_full = (reo_cnt >= REO_CW'(REO_AF));
  assign bus.ovf_err              = ovf_q;
  assign bus.out_meta_valid       = out_vld_q;
  assign bus.out_meta_data        = out_data_q;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == SRC_REO) ? SRC_FWD : p + 2'd1;
  endfunction

  assign load = ~out_vld_q | bus.out_meta_ready;
  assign ne   = {reo_cnt != '0, ino_cnt != '0, fwd_cnt != '0};

  // First non-empty source scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = rr_ptr;
    cand    = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_vld && ne[cand]) begin
        gnt     = cand;
        gnt_vld = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    gnt_data = fwd_head;
    case (gnt)
      SRC_INO: gnt_data = ino_head;
      SRC_REO: gnt_data = reo_head;
      default: gnt_data = fwd_head;
    endcase
  end

  assign pop_fwd = load & gnt_vld & (gnt == SRC_FWD);
  assign pop_ino = load & gnt_vld & (gnt == SRC_INO);
  assign pop_reo = load & gnt_vld & (gnt == SRC_REO);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      rr_ptr     <= SRC_FWD;
      ovf_q      <= 1'b0;
    end else begin
      if (load) begin
        out_vld_q <= gnt_vld;
        if (gnt_vld) begin
          out_data_q <= gnt_data;
          rr_ptr     <= rr_next(gnt);
        end
      end
      if (bus.ino_meta_valid && ino_cnt == INO_CW'(INO_DEPTH)) ovf_q <= 1'b1;
    end
  end

`ifdef MERGE_STATS_EN
  logic hs;
  assign hs = out_vld_q & bus.out_meta_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_check   <= '0;
      stat_forward <= '0;
      stat_drop    <= '0;
    end else if (hs) begin
      if (out_data_q.pkt_flags == PKT_CHECK)   stat_check   <= stat_check + 32'd1;
      if (out_data_q.pkt_flags == PKT_FORWARD) stat_forward <= stat_forward + 32'd1;
      if (out_data_q.pkt_flags == PKT_DROP)    stat_drop    <= stat_drop + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_reassembly_meta_merge.sv
module tb_reassembly_meta_merge;
  import reassembly_meta_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  reassembly_meta_merge_if bus();

`ifdef MERGE_STATS_EN
  logic [31:0] stat_check, stat_forward, stat_drop;
`endif

  reassembly_meta_merge dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MERGE_STATS_EN
    ,
    .stat_check(stat_check),
    .stat_forward(stat_forward),
    .stat_drop(stat_drop)
`endif
  );

  always #5 clk = ~clk;

  function automatic metadata_t mk(input logic [1:0] f, input logic [3:0] src, input logic [7:0] idx);
    metadata_t m;
    m.pkt_flags = f;
    m.flow_id   = {12'hA00, src};
    m.seq       = {24'h5A5A5A, idx};
    m.len       = {2'b01, src, idx};
    return m;
  endfunction

  // Advance one edge; everything is then driven and sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ino_meta_valid = 1'b0;
    bus.fwd_meta_valid = 1'b0;
    bus.reo_meta_valid = 1'b0;
    bus.ino_meta_data  = '0;
    bus.fwd_meta_data  = '0;
    bus.reo_meta_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.out_meta_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_meta_valid); else n_pass++;
    n_chk++; if (bus.fwd_meta_ready !== 1'b1) $display("FAIL reset_fwd_ready got %b want 1", bus.fwd_meta_ready); else n_pass++;
    n_chk++; if (bus.reo_meta_ready !== 1'b1) $display("FAIL reset_reo_ready got %b want 1", bus.reo_meta_ready); else n_pass++;
    n_chk++; if ({bus.ino_meta_almost_full, bus.reo_meta_almost_full} !== 2'b00)
      $display("FAIL reset_almost_full got %b%b want 00", bus.ino_meta_almost_full, bus.reo_meta_almost_full); else n_pass++;
    n_chk++; if (bus.ovf_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf_err); else n_pass++;
  endtask

  task automatic test_single();
    metadata_t d;
    do_reset();
    d = mk(PKT_FORWARD, 4'd2, 8'h33);
    bus.out_meta_ready = 1'b1;
    bus.ino_meta_valid = 1'b1;
    bus.ino_meta_data  = d;
    step();
    idle_inputs();
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL single_c0_valid got %b want 0", bus.out_meta_valid); else n_pass++;
    step();
    n_chk++; if (bus.out_meta_valid !== 1'b1) $display("FAIL single_c1_valid got %b want 1", bus.out_meta_valid); else n_pass++;
    n_chk++; if (bus.out_meta_data !== d) $display("FAIL single_c1_data got %h want %h", bus.out_meta_data, d); else n_pass++;
    step();
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL single_c2_valid got %b want 0", bus.out_meta_valid); else n_pass++;
  endtask

  task automatic test_round_robin();
    metadata_t exp;
    logic [3:0] src;
    logic [7:0] idx;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.fwd_meta_valid = 1'b1; bus.fwd_meta_data = mk(PKT_CHECK, 4'd1, 8'(i));
      bus.ino_meta_valid = 1'b1; bus.ino_meta_data = mk(PKT_CHECK, 4'd2, 8'(i));
      bus.reo_meta_valid = 1'b1; bus.reo_meta_data = mk(PKT_DROP,  4'd3, 8'(i));
      step();
    end
    idle_inputs();
    bus.out_meta_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      src = 4'(k % 3 + 1);
      idx = 8'(k / 3);
      exp = mk((src == 4'd3) ? PKT_DROP : PKT_CHECK, src, idx);
      n_chk++; if (bus.out_meta_valid !== 1'b1) $display("FAIL rr_valid_%0d got %b want 1", k, bus.out_meta_valid); else n_pass++;
      n_chk++; if (bus.out_meta_data !== exp) $display("FAIL rr_data_%0d got %h want %h", k, bus.out_meta_data, exp); else n_pass++;
      step();
    end
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL rr_end_valid got %b want 0", bus.out_meta_valid); else n_pass++;
  endtask

  // Output register pre-occupied by a FWD entry so INO count equals writes.
  task automatic test_ino_almost_full();
    metadata_t first;
    do_reset();
    first = mk(PKT_CHECK, 4'd1, 8'hEE);
    bus.fwd_meta_valid = 1'b1; bus.fwd_meta_data = first;
    step();
    idle_inputs();
    step();
    for (int i = 0; i < 34; i++) begin
      bus.ino_meta_valid = 1'b1; bus.ino_meta_data = mk(PKT_CHECK, 4'd2, 8'(i));
      step();
      if (i == 18) begin n_chk++; if (bus.ino_meta_almost_full !== 1'b0) $display("FAIL ino_af_19 got %b want 0", bus.ino_meta_almost_full); else n_pass++; end
      if (i == 19) begin n_chk++; if (bus.ino_meta_almost_full !== 1'b1) $display("FAIL ino_af_20 got %b want 1", bus.ino_meta_almost_full); else n_pass++; end
      if (i == 31) begin n_chk++; if (bus.ovf_err !== 1'b0) $display("FAIL ovf_32 got %b want 0", bus.ovf_err); else n_pass++; end
      if (i == 32) begin n_chk++; if (bus.ovf_err !== 1'b1) $display("FAIL ovf_33 got %b want 1", bus.ovf_err); else n_pass++; end
      if (i == 33) begin n_chk++; if (bus.ovf_err !== 1'b1) $display("FAIL ovf_34 got %b want 1", bus.ovf_err); else n_pass++; end
    end
    idle_inputs();
    bus.out_meta_ready = 1'b1;
    n_chk++; if (bus.out_meta_data !== first) $display("FAIL ino_drain_first got %h want %h", bus.out_meta_data, first); else n_pass++;
    step();
    for (int k = 0; k < 32; k++) begin
      n_chk++; if (bus.out_meta_valid !== 1'b1 || bus.out_meta_data !== mk(PKT_CHECK, 4'd2, 8'(k)))
        $display("FAIL ino_drain_%0d got %b/%h want 1/%h", k, bus.out_meta_valid, bus.out_meta_data, mk(PKT_CHECK, 4'd2, 8'(k))); else n_pass++;
      step();
    end
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL ino_drain_end got %b want 0", bus.out_meta_valid); else n_pass++;
    n_chk++; if (bus.ino_meta_almost_full !== 1'b0) $display("FAIL ino_af_after_drain got %b want 0", bus.ino_meta_almost_full); else n_pass++;
  endtask

  // Runs with ovf_err still set from the previous test.
  task automatic test_reset_mid();
    bus.out_meta_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ino_meta_valid = 1'b1; bus.ino_meta_data = mk(PKT_CHECK, 4'd2, 8'(i));
      bus.fwd_meta_valid = (i < 5); bus.fwd_meta_data = mk(PKT_CHECK, 4'd1, 8'(i));
      step();
    end
    idle_inputs();
    n_chk++; if ({bus.out_meta_valid, bus.fwd_meta_ready, bus.ovf_err} !== 3'b101)
      $display("FAIL rmid_pre got v/fr/ovf %b%b%b want 101", bus.out_meta_valid, bus.fwd_meta_ready, bus.ovf_err); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", bus.out_meta_valid); else n_pass++;
    n_chk++; if ({bus.fwd_meta_ready, bus.reo_meta_ready} !== 2'b11)
      $display("FAIL rmid_readies got %b%b want 11", bus.fwd_meta_ready, bus.reo_meta_ready); else n_pass++;
    n_chk++; if (bus.ovf_err !== 1'b0) $display("FAIL rmid_ovf got %b want 0", bus.ovf_err); else n_pass++;
    bus.out_meta_ready = 1'b1;
    step();
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL rmid_discard got %b want 0", bus.out_meta_valid); else n_pass++;
  endtask

  // Output register pre-occupied by an INO entry so FWD count equals writes.
  task automatic test_fwd_full();
    metadata_t occ;
    do_reset();
    occ = mk(PKT_FORWARD, 4'd2, 8'h77);
    bus.ino_meta_valid = 1'b1; bus.ino_meta_data = occ;
    step();
    idle_inputs();
    step();
    for (int i = 0; i < 4; i++) begin
      bus.fwd_meta_valid = 1'b1; bus.fwd_meta_data = mk(PKT_FORWARD, 4'd1, 8'(i));
      step();
      if (i == 2) begin n_chk++; if (bus.fwd_meta_ready !== 1'b1) $display("FAIL fwd_ready_3 got %b want 1", bus.fwd_meta_ready); else n_pass++; end
      if (i == 3) begin n_chk++; if (bus.fwd_meta_ready !== 1'b0) $display("FAIL fwd_ready_4 got %b want 0", bus.fwd_meta_ready); else n_pass++; end
    end
    bus.fwd_meta_data = mk(PKT_FORWARD, 4'd1, 8'h99);
    step();
    idle_inputs();
    bus.out_meta_ready = 1'b1;
    n_chk++; if (bus.fwd_meta_ready !== 1'b0) $display("FAIL fwd_ready_before_pop got %b want 0", bus.fwd_meta_ready); else n_pass++;
    n_chk++; if (bus.out_meta_data !== occ) $display("FAIL fwd_occ got %h want %h", bus.out_meta_data, occ); else n_pass++;
    step();
    n_chk++; if (bus.fwd_meta_ready !== 1'b1) $display("FAIL fwd_ready_after_pop got %b want 1", bus.fwd_meta_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (bus.out_meta_valid !== 1'b1 || bus.out_meta_data !== mk(PKT_FORWARD, 4'd1, 8'(k)))
        $display("FAIL fwd_drain_%0d got %b/%h want 1/%h", k, bus.out_meta_valid, bus.out_meta_data, mk(PKT_FORWARD, 4'd1, 8'(k))); else n_pass++;
      step();
    end
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL fwd_fifth_refused got %b want 0", bus.out_meta_valid); else n_pass++;
  endtask

  // Output register absorbs the first REO write, so FIFO count = writes - 1.
  task automatic test_reo_full();
    do_reset();
    for (int i = 0; i < 34; i++) begin
      bus.reo_meta_valid = 1'b1; bus.reo_meta_data = mk(PKT_DROP, 4'd3, 8'(i));
      step();
      if (i == 19) begin n_chk++; if (bus.reo_meta_almost_full !== 1'b0) $display("FAIL reo_af_19 got %b want 0", bus.reo_meta_almost_full); else n_pass++; end
      if (i == 20) begin n_chk++; if (bus.reo_meta_almost_full !== 1'b1) $display("FAIL reo_af_20 got %b want 1", bus.reo_meta_almost_full); else n_pass++; end
      if (i == 31) begin n_chk++; if (bus.reo_meta_ready !== 1'b1) $display("FAIL reo_ready_31 got %b want 1", bus.reo_meta_ready); else n_pass++; end
      if (i == 32) begin n_chk++; if (bus.reo_meta_ready !== 1'b0) $display("FAIL reo_ready_32 got %b want 0", bus.reo_meta_ready); else n_pass++; end
    end
    idle_inputs();
    n_chk++; if (bus.ovf_err !== 1'b0) $display("FAIL reo_no_ovf got %b want 0", bus.ovf_err); else n_pass++;
    bus.out_meta_ready = 1'b1;
    for (int k = 0; k < 33; k++) begin
      n_chk++; if (bus.out_meta_valid !== 1'b1 || bus.out_meta_data !== mk(PKT_DROP, 4'd3, 8'(k)))
        $display("FAIL reo_drain_%0d got %b/%h want 1/%h", k, bus.out_meta_valid, bus.out_meta_data, mk(PKT_DROP, 4'd3, 8'(k))); else n_pass++;
      step();
    end
    n_chk++; if (bus.out_meta_valid !== 1'b0) $display("FAIL reo_drain_end got %b want 0", bus.out_meta_valid); else n_pass++;
  endtask

`ifdef MERGE_STATS_EN
  task automatic test_stats();
    logic [1:0] fl;
    do_reset();
    bus.out_meta_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fl = (i < 5) ? PKT_CHECK : (i < 7) ? PKT_FORWARD : PKT_DROP;
      bus.ino_meta_valid = 1'b1; bus.ino_meta_data = mk(fl, 4'd2, 8'(i));
      step();
    end
    idle_inputs();
    repeat (4) step();
    n_chk++; if (stat_check !== 32'd5) $display("FAIL stat_check got %0d want 5", stat_check); else n_pass++;
    n_chk++; if (stat_forward !== 32'd2) $display("FAIL stat_forward got %0d want 2", stat_forward); else n_pass++;
    n_chk++; if (stat_drop !== 32'd1) $display("FAIL stat_drop got %0d want 1", stat_drop); else n_pass++;
    bus.out_meta_ready = 1'b0;
    bus.ino_meta_valid = 1'b1; bus.ino_meta_data = mk(PKT_CHECK, 4'd2, 8'h50);
    step();
    idle_inputs();
    repeat (4) step();
    n_chk++; if (bus.out_meta_valid !== 1'b1) $display("FAIL stat_hold_valid got %b want 1", bus.out_meta_valid); else n_pass++;
    n_chk++; if (stat_check !== 32'd5) $display("FAIL stat_check_held got %0d want 5", stat_check); else n_pass++;
  endtask
`endif

  initial begin
    idle_inputs();
    bus.out_meta_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_ino_almost_full();
    test_reset_mid();
    test_fwd_full();
    test_reo_full();
`ifdef MERGE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
